// File: rtl/mixed_nested_packer.sv
// mixed_nested_packer
// -------------------
// Width-up packer: gathers RATIO consecutive IN_UNITS-wide beats into one
// OUT_UNITS-wide word. A beat flagged in_last flushes a partial word. Unfilled
// lanes of that word are zero and their keep bits are clear.
// The default sizes (1 unit in, 2 units out) mirror the producer/consumer word
// sizes DSIZE=1 and DSIZE2=2 used by the surrounding stages.
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   packer accepts the beat this cycle (combinational from out_ready)
//   in_data    input beat, IN_UNITS*UNIT_BITS bits
//   in_last    final beat of a packet, forces a flush
//   out_valid  output word present
//   out_ready  consumer accepts the output word
//   out_data   packed word, lane 0 at the LSBs
//   out_keep   one valid bit per lane
//   out_last   word carries the packet's final beat
module mixed_nested_packer #(
  parameter int UNIT_BITS = 8,
  parameter int IN_UNITS  = 1,
  parameter int OUT_UNITS = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_UNITS*UNIT_BITS-1:0]       in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_UNITS*UNIT_BITS-1:0]      out_data,
  output logic [OUT_UNITS/IN_UNITS-1:0]       out_keep,
  output logic                                out_last
);

  localparam int RATIO = OUT_UNITS / IN_UNITS;
  localparam int IW    = IN_UNITS * UNIT_BITS;
  localparam int OW    = OUT_UNITS * UNIT_BITS;
  localparam int LCW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if ((OUT_UNITS % IN_UNITS) != 0 || OUT_UNITS < IN_UNITS) begin : g_bad_cfg
      $error("mixed_nested_packer: OUT_UNITS must be a non-zero multiple of IN_UNITS");
    end
  endgenerate

  logic [LCW-1:0]   lane_cnt_reg, lane_cnt_next;
  logic [OW-1:0]    acc_data_reg, acc_data_next;
  logic [RATIO-1:0] acc_keep_reg, acc_keep_next;
  logic [OW-1:0]    out_data_reg, out_data_next;
  logic [RATIO-1:0] out_keep_reg, out_keep_next;
  logic             out_last_reg, out_last_next;
  logic             out_valid_reg, out_valid_next;

  logic [OW-1:0]    merged_data;
  logic [RATIO-1:0] merged_keep;
  logic             accept;
  logic             complete;

  // A held word blocks intake; a word being drained this cycle frees the slot.
  assign in_ready = !rst && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || lane_cnt_reg == LCW'(RATIO - 1));

  // Accumulator merged with the current beat. Lanes above lane_cnt are still
  // zero in the accumulator, so a flushed partial word comes out zero-padded.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      logic hit;
      assign hit = (lane_cnt_reg == LCW'(gi));
      assign merged_data[gi*IW +: IW] = hit ? in_data : acc_data_reg[gi*IW +: IW];
      assign merged_keep[gi]          = hit | acc_keep_reg[gi];
    end
  endgenerate

  always_comb begin
    lane_cnt_next  = lane_cnt_reg;
    acc_data_next  = acc_data_reg;
    acc_keep_next  = acc_keep_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    out_valid_next = out_valid_reg;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    if (complete) begin
      // A load in the same cycle as a drain overrides the clear above.
      out_data_next  = merged_data;
      out_keep_next  = merged_keep;
      out_last_next  = in_last;
      out_valid_next = 1'b1;
      lane_cnt_next  = '0;
      acc_data_next  = '0;
      acc_keep_next  = '0;
    end else if (accept) begin
      lane_cnt_next = lane_cnt_reg + LCW'(1);
      acc_data_next = merged_data;
      acc_keep_next = merged_keep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_reg  <= '0;
      acc_data_reg  <= '0;
      acc_keep_reg  <= '0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      lane_cnt_reg  <= lane_cnt_next;
      acc_data_reg  <= acc_data_next;
      acc_keep_reg  <= acc_keep_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_keep  = out_keep_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_mixed_nested_packer.sv
// Self-checking bench for mixed_nested_packer with default sizes (8-bit units,
// 1 unit in, 2 units out). A directed vector table walks the basic, flush,
// backpressure, streaming, drain+load and reset cases. A short hand sequence
// covers back-to-back single-lane flushes. A random phase is then checked
// against a word-level scoreboard model.
module tb_mixed_nested_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_last;

  mixed_nested_packer #(.UNIT_BITS(8), .IN_UNITS(1), .OUT_UNITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle, the in_ready expected before the
  // edge, and the registered outputs expected after it.
  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        exp_irdy;
    logic        exp_ov;
    logic [15:0] exp_od;
    logic [1:0]  exp_ok;
    logic        exp_ol;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                     input logic ordy, input logic irdy, input logic ov,
                     input logic [15:0] od, input logic [1:0] ok, input logic ol);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.l = l; t.ordy = ordy;
    t.exp_irdy = irdy; t.exp_ov = ov; t.exp_od = od; t.exp_ok = ok; t.exp_ol = ol;
    vecs.push_back(t);
  endtask

  // Scoreboard model: beats gathered per output word, completed words queued.
  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } word_t;

  logic [7:0] grp[$];
  word_t      expq[$];

  function automatic word_t build_word(input logic last);
    word_t w;
    w.d = '0;
    w.k = '0;
    for (int i = 0; i < grp.size(); i++) begin
      w.d = w.d | (16'(grp[i]) << (8 * i));
      w.k[i] = 1'b1;
    end
    w.l = last;
    return w;
  endfunction

  initial begin
    word_t w;
    logic  drain, acc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 16'h0000);
    chk("reset_out_keep", out_keep, 2'b00);
    chk("reset_out_last", out_last, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1'b1);

    //   r  v  d      l  ordy irdy ov  data      keep   last
    add(0, 1, 8'hA1, 0, 1,   1,   0, 16'h0000, 2'b00, 0);   // basic pack
    add(0, 1, 8'hB2, 0, 1,   1,   1, 16'hB2A1, 2'b11, 0);
    add(0, 1, 8'h01, 0, 0,   0,   1, 16'hB2A1, 2'b11, 0);   // backpressure x3
    add(0, 1, 8'h01, 0, 0,   0,   1, 16'hB2A1, 2'b11, 0);
    add(0, 1, 8'h01, 0, 0,   0,   1, 16'hB2A1, 2'b11, 0);
    add(0, 1, 8'h01, 0, 1,   1,   0, 16'hB2A1, 2'b11, 0);   // drain, 0x01 taken
    add(0, 1, 8'h02, 0, 1,   1,   1, 16'h0201, 2'b11, 0);
    add(0, 1, 8'hC3, 1, 1,   1,   1, 16'h00C3, 2'b01, 1);   // drain+load, partial
    add(0, 1, 8'h11, 0, 1,   1,   0, 16'h00C3, 2'b01, 1);
    add(0, 1, 8'h22, 1, 1,   1,   1, 16'h2211, 2'b11, 1);
    add(0, 0, 8'h00, 0, 1,   1,   0, 16'h2211, 2'b11, 1);
    add(0, 1, 8'h00, 0, 1,   1,   0, 16'h2211, 2'b11, 1);   // streaming 0..7
    add(0, 1, 8'h01, 0, 1,   1,   1, 16'h0100, 2'b11, 0);
    add(0, 1, 8'h02, 0, 1,   1,   0, 16'h0100, 2'b11, 0);
    add(0, 1, 8'h03, 0, 1,   1,   1, 16'h0302, 2'b11, 0);
    add(0, 1, 8'h04, 0, 1,   1,   0, 16'h0302, 2'b11, 0);
    add(0, 1, 8'h05, 0, 1,   1,   1, 16'h0504, 2'b11, 0);
    add(0, 1, 8'h06, 0, 1,   1,   0, 16'h0504, 2'b11, 0);
    add(0, 1, 8'h07, 0, 1,   1,   1, 16'h0706, 2'b11, 0);
    add(0, 1, 8'hEE, 0, 1,   1,   0, 16'h0706, 2'b11, 0);   // reset mid-packet
    add(1, 0, 8'h00, 0, 1,   0,   0, 16'h0000, 2'b00, 0);
    add(0, 1, 8'h55, 0, 1,   1,   0, 16'h0000, 2'b00, 0);
    add(0, 1, 8'h66, 0, 1,   1,   1, 16'h6655, 2'b11, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; in_valid = vecs[i].v; in_data = vecs[i].d;
      in_last = vecs[i].l; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_irdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      chk($sformatf("vec%0d_out_keep", i), out_keep, vecs[i].exp_ok);
      chk($sformatf("vec%0d_out_last", i), out_last, vecs[i].exp_ol);
      $display("vec %0d: r=%0b v=%0b d=%h l=%0b ordy=%0b -> ov=%0b data=%h keep=%b last=%0b",
               i, vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy,
               out_valid, out_data, out_keep, out_last);
    end
    rst = 1'b0;

    // Back-to-back single-lane flushes: every beat forms its own word and
    // out_valid stays high while the previous word drains.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h90 + 8'(i); in_last = 1'b1; out_ready = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("flush_out_valid", out_valid, 1'b1);
      chk("flush_out_data", out_data, {8'h00, 8'h90 + 8'(i)});
      chk("flush_out_keep", out_keep, 2'b01);
      chk("flush_out_last", out_last, 1'b1);
      $display("flush %0d: data=%h keep=%b last=%0b", i, out_data, out_keep, out_last);
    end

    // Clean restart for the random phase so the model starts empty.
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_out_valid", out_valid, expq.size() != 0);
      chk("rnd_in_ready", in_ready, (expq.size() == 0) || out_ready);
      drain = out_valid && out_ready;
      acc   = in_valid && in_ready;
      if (drain && expq.size() != 0) begin
        w = expq.pop_front();
        chk("rnd_out_data", out_data, w.d);
        chk("rnd_out_keep", out_keep, w.k);
        chk("rnd_out_last", out_last, w.l);
        $display("rnd word: data=%h keep=%b last=%0b", out_data, out_keep, out_last);
      end
      if (acc) begin
        grp.push_back(in_data);
        if (in_last || grp.size() == 2) begin
          expq.push_back(build_word(in_last));
          grp.delete();
        end
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
